// File: rtl/goertzel_tone_gen.sv
`default_nettype none
// ============================================================================
// goertzel_tone_gen : burst sine-tone source using the Goertzel resonator,
// streaming SIZE samples of DFT bin k over valid/ready.
// TONE_GEN_CONT_EN: start_i at the final handshake chains a new burst.
// Revision: 1.0
// ============================================================================
module goertzel_tone_gen #(
  parameter real FREQ      = 457000.0,
  parameter int  SIZE      = 256,
  parameter real SAMP_RATE = 1.0e6,
  parameter int  AMPLITUDE = 16384
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               ready_i,
  output logic signed [15:0] data_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int  COEFF_BITS = 24;
  localparam int  STATE_FRAC = 8;
  localparam real PI         = 3.14159265358979323846;
  localparam int  K          = $rtoi(0.5 + $itor(SIZE) * FREQ / SAMP_RATE);
  localparam real OMEGA      = 2.0 * PI * $itor(K) / $itor(SIZE);
  localparam int  COEFF      = $rtoi(2.0 * $cos(OMEGA) * $itor(1 << COEFF_BITS));
  localparam int  INIT       = $rtoi($itor(AMPLITUDE) * $sin(OMEGA) * $itor(1 << STATE_FRAC));
  localparam int  CW         = $clog2(SIZE);

  localparam logic [63:0]        COEFF_X  = 64'(COEFF);
  localparam logic signed [31:0] NEG_INIT = 32'(-INIT);
  localparam logic [CW-1:0]      LAST     = CW'(SIZE - 1);
  localparam logic signed [31:0] HALF_LSB = 32'sd1 <<< (STATE_FRAC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic signed [31:0] r_cur;
  logic signed [31:0] r_prev;
  logic [CW-1:0]      r_count;

  logic [63:0]        w_cur_x;
  logic [63:0]        w_prod;
  logic signed [31:0] w_nxt;
  logic signed [31:0] w_rnd;
  logic signed [15:0] w_sat;
  logic               w_unused;

  // Low 64 bits of the product are sign-agnostic, so plain extension suffices.
  assign w_cur_x  = {{32{r_cur[31]}}, r_cur};
  assign w_prod   = w_cur_x * COEFF_X;
  assign w_nxt    = $signed(w_prod[55:24]) - r_prev;
  assign w_rnd    = (w_nxt + HALF_LSB) >>> STATE_FRAC;
  assign w_unused = ^{w_prod[63:56], w_prod[23:0]};

  always_comb begin
    w_sat = w_rnd[15:0];
    if (w_rnd > 32'sd32767)
      w_sat = 16'sh7FFF;
    else if (w_rnd < -32'sd32768)
      w_sat = 16'sh8000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_prev  <= '0;
      r_count <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_LOAD;
            busy_o  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_cur   <= '0;
          r_prev  <= NEG_INIT;
          r_count <= '0;
          data_o  <= '0;
          valid_o <= 1'b1;
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (ready_i) begin
            if (r_count == LAST) begin
`ifdef TONE_GEN_CONT_EN
              if (start_i) begin
                r_cur   <= '0;
                r_prev  <= NEG_INIT;
                r_count <= '0;
                data_o  <= '0;
                done_o  <= 1'b1;
              end else
`endif
              begin
                r_state <= S_DONE;
                valid_o <= 1'b0;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
              end
            end else begin
              r_prev  <= r_cur;
              r_cur   <= w_nxt;
              r_count <= r_count + 1'b1;
              data_o  <= w_sat;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_goertzel_tone_gen.sv
`default_nettype none
// Self-checking bench for goertzel_tone_gen: quarter-rate and eighth-rate
// instances against an ideal-sine reference.
module tb_goertzel_tone_gen;

  localparam int  N    = 8;
  localparam real SR   = 1.0e6;
  localparam real F_Q  = 250000.0;
  localparam real F_E  = 125000.0;
  localparam int  AMP  = 16384;
  localparam real PI   = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;

  logic signed [15:0] data_q, data_e;
  logic valid_q, busy_q, done_q;
  logic valid_e, busy_e, done_e;

  int checks = 0;
  int passed = 0;

  int exp_q [N];
  int exp_e [N];

  always #5 clk = ~clk;

  goertzel_tone_gen #(.FREQ(F_Q), .SIZE(N), .SAMP_RATE(SR), .AMPLITUDE(AMP)) dut_q (
    .clk(clk), .rst_n(rst_n), .start_i(start), .ready_i(ready),
    .data_o(data_q), .valid_o(valid_q), .busy_o(busy_q), .done_o(done_q)
  );

  goertzel_tone_gen #(.FREQ(F_E), .SIZE(N), .SAMP_RATE(SR), .AMPLITUDE(AMP)) dut_e (
    .clk(clk), .rst_n(rst_n), .start_i(start), .ready_i(ready),
    .data_o(data_e), .valid_o(valid_e), .busy_o(busy_e), .done_o(done_e)
  );

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  // Ideal tone: A*sin(2*pi*k*n/SIZE) with k the nearest DFT bin.
  function automatic int ideal(input real f, input int n);
    int  k;
    k = $rtoi(0.5 + $itor(N) * f / SR);
    return rnd($itor(AMP) * $sin(2.0 * PI * $itor(k) * $itor(n) / $itor(N)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int expv);
    checks++;
    assert (((obs - expv) <= 1) && ((obs - expv) >= -1)) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d +/-1", tag, obs, expv);
    end
  endtask

  task automatic check_samples(input int n);
    check("sample_q", data_q, exp_q[n % N]);
    check_tol("sample_e", int'(data_e), exp_e[n % N]);
  endtask

  // mode 0: ready always; 1: ready one cycle in three; 2: random ready.
  task automatic run_burst(input int mode, input bit noise, input int abort_at);
    int idx;
    int guard;
    int phase;
    bit stalled;
    logic signed [15:0] last_q;
    start = 1'b1;
    ready = 1'b0;
    tick();
    start = 1'b0;
    check("load_busy", busy_q, 1);
    check("load_valid", valid_q, 0);
    tick();
    idx = 0; guard = 0; phase = 0; stalled = 1'b0; last_q = '0;
    while (idx < N && guard < 200) begin
      check("stream_valid", valid_q, 1);
      check("stream_valid_e", valid_e, 1);
      check("stream_done", done_q, 0);
      check_samples(idx);
      if (stalled) check("stall_hold", data_q, last_q);
      if (idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid", valid_q, 0);
        check("abort_busy", busy_q, 0);
        check("abort_data", data_q, 0);
        tick();
        rst_n = 1'b1;
        ready = 1'b0;
        tick();
        check("abort_idle", {valid_q, busy_q, done_q}, 0);
        return;
      end
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (phase % 3 == 2);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      phase++;
      start = (noise && idx >= 1 && idx < N - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      last_q = data_q;
      stalled = !ready;
      tick();
      if (ready) idx++;
      guard++;
    end
    check("burst_complete", idx, N);
    ready = 1'b0;
    start = 1'b0;
    check("done_pulse", done_q, 1);
    check("done_valid", valid_q, 0);
    check("done_busy", busy_q, 0);
    tick();
    check("idle_done", done_q, 0);
    check("idle_busy", busy_q, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < N; n++) begin
      exp_q[n] = ideal(F_Q, n);
      exp_e[n] = ideal(F_E, n);
    end

    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      start = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      tick();
      check("reset_q", {data_q, valid_q, busy_q, done_q}, 0);
      check("reset_e", {data_e, valid_e, busy_e, done_e}, 0);
    end
    start = 1'b0;
    ready = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {data_q, valid_q, busy_q, done_q}, 0);

    run_burst(0, 1'b0, -1);
    run_burst(1, 1'b0, -1);
    run_burst(2, 1'b1, -1);
    run_burst(0, 1'b1, 3);
    run_burst(0, 1'b0, -1);

    // start_i held high through the final handshake.
    start = 1'b1;
    ready = 1'b1;
    tick();
    check("hold_load_busy", busy_q, 1);
    tick();
`ifdef TONE_GEN_CONT_EN
    for (int n = 0; n < 2 * N; n++) begin
      check("cont_valid", valid_q, 1);
      check("cont_done", done_q, (n == N) ? 1 : 0);
      check_samples(n);
      if (n == 2 * N - 1) start = 1'b0;
      tick();
    end
`else
    for (int n = 0; n < N; n++) begin
      check("hold_valid", valid_q, 1);
      check_samples(n);
      tick();
    end
    start = 1'b0;
`endif
    check("hold_done", done_q, 1);
    check("hold_end_valid", valid_q, 0);
    ready = 1'b0;
    tick();
    check("hold_idle", {valid_q, busy_q, done_q}, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
